nonconsec_pulse_sched: RTL
==========================

// Module: nonconsec_pulse_sched
// PURPOSE
//  Sequencer for the trigger/response pair a -> b[=N] used by our protocol assertions.
//  - On a rising edge of trig_i it issues exactly PULSES single-cycle pulses on pulse_o.
//  - Pulses are gated by ready_i and separated by at least MIN_GAP idle cycles, so they are never consecutive.
//  - An overall TIMEOUT window bounds the sequence.
//  - Sits between the stimulus/trigger source and the consumer whose b-strobe the $rose(a) |-> strong(b[=N]) check monitors.
// PARAMETERS
//  PULSES   2   pulses per trigger, >=1
//  MIN_GAP  1   idle cycles forced after each pulse, >=1
//  TIMEOUT  16  max cycles spent in ISSUE+GAP before abort, > PULSES*(MIN_GAP+1)
//  CNT_W    $clog2(TIMEOUT+1)   derived, localparam
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst        in   1      asynchronous, active-high reset
//  trig_i     in   1      trigger level; sequence starts on 0->1
//  ready_i    in   1      consumer may accept a pulse this cycle
//  pulse_o    out  1      one-cycle strobe (the "b" event), registered
//  busy_o     out  1      high in ISSUE, GAP or DONE
//  done_o     out  1      one-cycle strobe, all PULSES issued
//  timeout_o  out  1      one-cycle strobe, sequence aborted
//  count_o    out  CNT_W  pulses issued in current or last sequence
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, trig_q=0, counters 0. A trig_i high at the first edge after reset counts as a rise.
//  - Edge detect: rise = trig_i & ~trig_q, with trig_q registered every cycle.
//  - IDLE:
//    - On rise: go to ISSUE, clear count_o and the timer.
//    - Otherwise stay in IDLE.
//  - ISSUE with ready_i=1:
//    - Next cycle pulse_o=1 and count_o++.
//    - Go to GAP if count_o+1 < PULSES, else go to DONE.
//  - ISSUE with ready_i=0: stay in ISSUE, pulse_o=0.
//  - GAP: pulse_o=0 for MIN_GAP cycles (gap counter), then return to ISSUE.
//  - DONE: done_o=1 for one cycle, then IDLE. pulse_o is 0 in DONE.
//  - Timer:
//    - Increments every cycle in ISSUE or GAP.
//    - If timer==TIMEOUT-1 on a posedge in ISSUE/GAP: timeout_o=1 next cycle, state goes to IDLE, count_o holds.
//    - Timeout beats a simultaneous ready_i, so no pulse is issued that cycle.
//  - Retrigger: a rise while busy_o=1 is ignored, not queued. A rise in the DONE cycle is also ignored.
//  - Latency:
//    - First pulse_o can occur 2 cycles after the posedge that sees the rise.
//    - Minimum spacing between pulses is MIN_GAP+1 cycles.
//  - Non-overlap: pulse_o, done_o and timeout_o are mutually exclusive in every cycle.
//  - Reset mid-sequence: immediate return to reset values; no done_o or timeout_o is emitted.
//  - Widths: count_o saturates at PULSES by construction. Elaboration error if PULSES<1, MIN_GAP<1, or TIMEOUT is too small.
// STRUCTURE
//  - nonconsec_pkg: state enum state_t {IDLE, ISSUE, GAP, DONE}, plus a check function for PULSES/MIN_GAP/TIMEOUT legality.
//  - Sub-module rise_detect (clk, rst, d, rise): one-flop edge detector, reused by other blocks.
//  - FSM, gap counter, timer and pulse counter live in this module.
//  - Bind the assertion $rose(trig_i) |-> strong(pulse_o[=PULSES]) plus an exclusivity check in the bench.
// TESTING
//  - Basic sequence:
//    - Stimulus: PULSES=2, MIN_GAP=1, ready_i=1, trig_i rises at cycle 0.
//    - Response: pulse_o high in cycles 2 and 4, done_o high in cycle 5, count_o=2.
//  - Ready stall:
//    - Stimulus: ready_i low for cycles 0-5, then high.
//    - Response: first pulse_o at cycle 7, second at cycle 9, no timeout.
//  - Timeout:
//    - Stimulus: TIMEOUT=16, ready_i=0 throughout.
//    - Response: timeout_o high in cycle 17, no pulse_o, count_o=0, busy_o drops in cycle 17.
//  - Timeout vs ready:
//    - Stimulus: ready_i rises on the same edge the timer hits 15.
//    - Response: timeout_o asserts and no pulse is issued.
//  - Retrigger while busy:
//    - Stimulus: trig_i pulsed again at cycle 3.
//    - Response: exactly 2 pulses total. A new rise after done_o starts a fresh sequence.
//  - Reset mid-sequence:
//    - Stimulus: rst asserted asynchronously after the first pulse.
//    - Response: all outputs 0 within the same cycle, no done_o. trig_i still high after rst release gives a new sequence.

Source files
------------

// File: rtl/nonconsec_pulse_sched_pkg.sv
// Shared types and parameter legality check for the non-consecutive pulse sequencer.
package nonconsec_pulse_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  // The timeout window must leave room for every pulse plus its forced gap.
  function automatic bit params_legal(int pulses, int min_gap, int timeout);
    return (pulses >= 1) && (min_gap >= 1) && (timeout > pulses * (min_gap + 1));
  endfunction

endpackage

// File: rtl/nonconsec_pulse_sched_if.sv
// Trigger/ready inputs and pulse/status outputs of the pulse sequencer.
interface nonconsec_pulse_sched_if #(
  parameter int CNT_W = 5
);
  logic             trig_i;
  logic             ready_i;
  logic             pulse_o;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;
  logic [CNT_W-1:0] count_o;

  modport master (
    output trig_i, ready_i,
    input  pulse_o, busy_o, done_o, timeout_o, count_o
  );

  modport slave (
    input  trig_i, ready_i,
    output pulse_o, busy_o, done_o, timeout_o, count_o
  );
endinterface

// File: rtl/nonconsec_pulse_sched_rise_detect.sv
// One-flop rising-edge detector; the flop clears on reset so a high input right after reset reads as a rise.
module nonconsec_pulse_sched_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;
endmodule

// File: rtl/nonconsec_pulse_sched.sv
// Issues PULSES ready-gated single-cycle pulses per trigger rise, at least MIN_GAP idle cycles apart,
// aborting if the sequence spends TIMEOUT cycles in ISSUE/GAP.
module nonconsec_pulse_sched
  import nonconsec_pulse_sched_pkg::*;
#(
  parameter int PULSES  = 2,
  parameter int MIN_GAP = 1,
  parameter int TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    rst,
  nonconsec_pulse_sched_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PULSES - 1);
  localparam logic [CNT_W-1:0] TIMER_END = CNT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(MIN_GAP - 1);

  if (!params_legal(PULSES, MIN_GAP, TIMEOUT)) begin : g_bad_params
    $error("nonconsec_pulse_sched: illegal PULSES/MIN_GAP/TIMEOUT combination");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             pulse, pulse_nxt;
  logic             done, done_nxt;
  logic             tmo, tmo_nxt;
  logic             rise;
  logic             timer_hit;

  nonconsec_pulse_sched_rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.trig_i),
    .rise (rise)
  );

  assign timer_hit = (timer == TIMER_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      count   <= '0;
      gap_cnt <= '0;
      pulse   <= 1'b0;
      done    <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      count   <= count_nxt;
      gap_cnt <= gap_nxt;
      pulse   <= pulse_nxt;
      done    <= done_nxt;
      tmo     <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    count_nxt = count;
    gap_nxt   = gap_cnt;
    pulse_nxt = 1'b0;
    done_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = ISSUE;
          count_nxt = '0;
          timer_nxt = '0;
        end
      end
      ISSUE: begin
        // The abort takes priority over a pulse that ready_i would otherwise allow.
        if (timer_hit) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + CNT_W'(1);
          if (bus.ready_i) begin
            pulse_nxt = 1'b1;
            count_nxt = count + CNT_W'(1);
            gap_nxt   = '0;
            state_nxt = (count == LAST_CNT) ? DONE : GAP;
          end
        end
      end
      GAP: begin
        if (timer_hit) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + CNT_W'(1);
          if (gap_cnt == GAP_END) state_nxt = ISSUE;
          else                    gap_nxt   = gap_cnt + GAP_W'(1);
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pulse_o   = pulse;
  assign bus.busy_o    = (state != IDLE);
  assign bus.done_o    = done;
  assign bus.timeout_o = tmo;
  assign bus.count_o   = count;
endmodule
